// File: rtl/chacha_pkg.sv
// chacha_pkg: shared ChaCha20 constants, QR schedule, controller states and state builder
package chacha_pkg;
    typedef logic [31:0] word_t;
    localparam logic [0:3][31:0] CHACHA_CONST = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
    // word indices (a,b,c,d) for Q0..Q3 (columns) then Q4..Q7 (diagonals)
    localparam logic [0:7][0:3][3:0] QR_IDX = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15},
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_QR, S_ADD, S_OUT, S_FIN} state_t;
    // word i of the 16-word state sits at [32i+31:32i]
    function automatic logic [511:0] init_state(logic [255:0] key, logic [95:0] nonce, word_t ctr);
        init_state = {nonce, ctr, key, CHACHA_CONST[3], CHACHA_CONST[2], CHACHA_CONST[1], CHACHA_CONST[0]};
    endfunction
endpackage

// File: rtl/chacha_qr_sched.sv
// chacha_qr_sched: maps QR index 0..7 to its four state word indices
//   qidx in : quarter-round number within a double round
//   ia..id out : word indices for operands a,b,c,d
module chacha_qr_sched
    import chacha_pkg::*;
(
    input  logic [2:0] qidx,
    output logic [3:0] ia,
    output logic [3:0] ib,
    output logic [3:0] ic,
    output logic [3:0] id
);
    assign ia = QR_IDX[qidx][0];
    assign ib = QR_IDX[qidx][1];
    assign ic = QR_IDX[qidx][2];
    assign id = QR_IDX[qidx][3];
endmodule

// File: rtl/chacha20_block_ctrl.sv
// chacha20_block_ctrl: ChaCha20 block sequencer driving an external quarter-round unit
//   clk, rst_n (async active-low); start/abort job control; key/nonce/counter_init/num_blocks job inputs
//   busy, done status; qr_req/qr_*_in operands, qr_ack/qr_*_out results
//   ks_valid/ks_ready/ks_data/ks_last keystream stream; err counter-wrap flag
//   Optional: CHACHA_CTR_WRAP_ERR_EN stops the job with sticky err on counter wrap
module chacha20_block_ctrl
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20,
    parameter int NBLK_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [255:0]      key,
    input  logic [95:0]       nonce,
    input  logic [31:0]       counter_init,
    input  logic [NBLK_W-1:0] num_blocks,
    output logic              busy,
    output logic              done,
    output logic              qr_req,
    output logic [31:0]       qr_a_in,
    output logic [31:0]       qr_b_in,
    output logic [31:0]       qr_c_in,
    output logic [31:0]       qr_d_in,
    input  logic              qr_ack,
    input  logic [31:0]       qr_a_out,
    input  logic [31:0]       qr_b_out,
    input  logic [31:0]       qr_c_out,
    input  logic [31:0]       qr_d_out,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic [511:0]      ks_data,
    output logic              ks_last,
    output logic              err
);
    localparam int DR_W = $clog2(ROUNDS / 2 + 1);

    state_t            state, nxt;
    logic [255:0]      key_q;
    logic [95:0]       nonce_q;
    word_t             ctr;
    logic [NBLK_W-1:0] nblk;
    logic [511:0]      work, init;
    logic [2:0]        qidx;
    logic [DR_W-1:0]   dr;
    logic [3:0]        ia, ib, ic, id;
    logic              hs, last_qr, wrap_stop;

    chacha_qr_sched u_sched (.qidx(qidx), .ia(ia), .ib(ib), .ic(ic), .id(id));

    assign hs      = ks_valid & ks_ready;
    assign last_qr = qidx == 3'd7 && dr == DR_W'(ROUNDS / 2 - 1);

`ifdef CHACHA_CTR_WRAP_ERR_EN
    assign wrap_stop = ctr == 32'hFFFF_FFFF && nblk != NBLK_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (!abort && state == S_IDLE && start)
            err <= 1'b0;
        else if (!abort && state == S_OUT && hs && wrap_stop)
            err <= 1'b1;
    end
`else
    assign wrap_stop = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = num_blocks == '0 ? S_FIN : S_LOAD;
            S_LOAD:  nxt = S_QR;
            S_QR:    if (qr_ack && last_qr) nxt = S_ADD;
            S_ADD:   nxt = S_OUT;
            S_OUT:   if (hs) nxt = (nblk == NBLK_W'(1) || wrap_stop) ? S_FIN : S_LOAD;
            S_FIN:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    always_comb begin
        busy    = state != S_IDLE;
        done    = state == S_FIN;
        qr_req  = state == S_QR;
        qr_a_in = work[{ia, 5'b0} +: 32];
        qr_b_in = work[{ib, 5'b0} +: 32];
        qr_c_in = work[{ic, 5'b0} +: 32];
        qr_d_in = work[{id, 5'b0} +: 32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= '0;
            nonce_q  <= '0;
            ctr      <= '0;
            nblk     <= '0;
            work     <= '0;
            init     <= '0;
            qidx     <= '0;
            dr       <= '0;
            ks_data  <= '0;
            ks_valid <= 1'b0;
            ks_last  <= 1'b0;
        end else if (abort) begin
            ks_valid <= 1'b0;
            ks_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    key_q   <= key;
                    nonce_q <= nonce;
                    ctr     <= counter_init;
                    nblk    <= num_blocks;
                end
                S_LOAD: begin
                    work <= init_state(key_q, nonce_q, ctr);
                    init <= init_state(key_q, nonce_q, ctr);
                    qidx <= '0;
                    dr   <= '0;
                end
                S_QR: if (qr_ack) begin
                    work[{ia, 5'b0} +: 32] <= qr_a_out;
                    work[{ib, 5'b0} +: 32] <= qr_b_out;
                    work[{ic, 5'b0} +: 32] <= qr_c_out;
                    work[{id, 5'b0} +: 32] <= qr_d_out;
                    qidx <= qidx + 3'd1;
                    if (qidx == 3'd7) dr <= dr + 1'b1;
                end
                S_ADD: begin
                    for (int i = 0; i < 16; i++)
                        ks_data[32*i +: 32] <= work[32*i +: 32] + init[32*i +: 32];
                    ks_valid <= 1'b1;
                    ks_last  <= nblk == NBLK_W'(1);
                end
                S_OUT: if (hs) begin
                    ks_valid <= 1'b0;
                    ks_last  <= 1'b0;
                    ctr      <= ctr + 32'd1;
                    nblk     <= nblk - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/chacha20_block_ctrl.md
Name: chacha20_block_ctrl

Overview:
Sequencer for the ChaCha20 block function built around an external quarter-round (QR) unit. On `start` it captures the inputs and builds the 16-word initial state. It then issues 10 double rounds (column QRs Q0–Q3, then diagonal QRs Q4–Q7) over a req/ack interface, adds the initial state back, and streams 512-bit keystream blocks with valid/ready. It sits between the AEAD top (key/nonce/counter source, keystream consumer) and the QR datapath.

Parameters:
ROUNDS, 20, total rounds; must be even and ≥2; double rounds = ROUNDS/2.
NBLK_W, 16, width of `num_blocks`.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a job; accepted only in IDLE
abort  in  1  synchronous cancel
key  in  256  key; word k = key[32k+31:32k], k=0..7
nonce  in  96  nonce; word n = nonce[32n+31:32n]
counter_init  in  32  first block counter
num_blocks  in  NBLK_W  number of blocks to generate
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at job end
qr_req  out  1  QR operands valid
qr_a_in, qr_b_in, qr_c_in, qr_d_in  out  32 each  QR operands
qr_ack  in  1  QR results valid
qr_a_out, qr_b_out, qr_c_out, qr_d_out  in  32 each  QR results
ks_valid  out  1  keystream block valid
ks_ready  in  1  consumer ready
ks_data  out  512  word i at [32i+31:32i]
ks_last  out  1  high with the final block of a job
err  out  1  counter-wrap error, sticky (only with the optional feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE.
  - All outputs 0, including ks_data, done and err.
  - Internal state words, round counter, QR index and block count all 0.
- State layout:
  - w0..w3 = 61707865, 3320646e, 79622d32, 6b206574.
  - w4..w11 = key words 0..7.
  - w12 = block counter.
  - w13..w15 = nonce words 0..2.
- QR index schedule (word indices a,b,c,d):
  - Q0 (0,4,8,12), Q1 (1,5,9,13), Q2 (2,6,10,14), Q3 (3,7,11,15).
  - Q4 (0,5,10,15), Q5 (1,6,11,12), Q6 (2,7,8,13), Q7 (3,4,9,14).
- States:
  - IDLE: on `start`, capture key, nonce, counter_init and num_blocks. If num_blocks==0, go to FIN; else go to LOAD.
  - LOAD (1 cycle): working state and saved initial state both load from the captured inputs plus the current counter. Reset qidx=0, dr=0. Go to QR.
  - QR: qr_req=1, operands = working state at schedule[qidx].
    - On qr_ack: write the four results back to those indices and increment qidx.
    - qidx 7→0 increments dr. After dr reaches ROUNDS/2, go to ADD.
    - qr_req stays high across consecutive QRs; with operands updated the cycle after each ack.
  - ADD (1 cycle): ks_data word i = working[i] + initial[i], mod 2^32. Set ks_valid. ks_last = (remaining blocks == 1). Go to OUT.
  - OUT: ks_data, ks_valid and ks_last are held stable until ks_valid & ks_ready. On handshake, ks_valid drops next cycle and the counter increments (mod 2^32). If blocks remain, go to LOAD; else go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Latency: with qr_ack tied high, ks_valid rises 2+8·(ROUNDS/2) cycles after the start-accept edge (82 for ROUNDS=20).
- start while busy: ignored; no re-capture.
- abort: highest priority over every other event. Next cycle: IDLE, qr_req=0, ks_valid=0, no done pulse. err is unaffected.
- qr_ack while qr_req=0: ignored.
- Back-to-back jobs: start in the same cycle as FIN is ignored; it is accepted from IDLE.

Optional Feature:
CHACHA_CTR_WRAP_ERR_EN.
- Defined: if a block handshake occurs with counter==FFFFFFFF and more blocks remain, set err=1 (sticky until reset or next accepted start). Go to FIN without generating further blocks.
- Undefined: the counter wraps to 0 silently and err is tied to 0.

Decomposition:
- Package chacha_pkg: word_t (32-bit), CHACHA_CONST[4], QR_IDX table [8][4] of 4-bit indices, controller state enum.
- One sub-module, chacha_qr_sched: maps qidx to the four word indices (combinational lookup). Kept separate so the schedule can be verified in isolation.

Test Plan:
- Key 00..1f, nonce 000000090000004a00000000, counter 1, 1 block, qr_ack tied to a reference QR model → ks_data w0=e4e7f110, w15=4e3c50a2 (RFC 7539 §2.3.2); ks_last=1; done pulses once; latency 82.
- Same inputs, num_blocks=3, ks_ready low for 5 cycles per block → data stable while stalled; w12 input to each block is 1, 2, 3; ks_last only on the third block.
- qr_ack with random 0–3 cycle delays → identical ks_data to the immediate-ack run; no result written without ack.
- abort mid-QR (dr=4), then a new start → qr_req=0 next cycle, no done; the new job's output matches its golden value.
- num_blocks=0 → done one cycle after FIN entry; ks_valid never asserts. start while busy → ignored.
- counter_init=FFFFFFFF, 2 blocks:
  - with CHACHA_CTR_WRAP_ERR_EN → one block, then err=1 and done.
  - without it → the second block uses counter 0.
